// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the control FSM, the decoder and the datapath.
// Contents:
//   state_t      - control FSM state encoding
//   FT_*         - instruction class codes carried on flag_type
//   COND_*       - condition codes carried on cond (the decoder's rdst field)
//   OP_CMP       - compare opcode (updates flags without writing a register)
//   route_class  - DECODE routing: class code -> next state
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM_RD = 3'd3,
    ST_LD_WB  = 3'd4,
    ST_MEM_WR = 3'd5,
    ST_BRANCH = 3'd6
  } state_t;

  localparam logic [3:0] FT_WAIT   = 4'b0000;
  localparam logic [3:0] FT_R      = 4'b0001;
  localparam logic [3:0] FT_I      = 4'b0010;
  localparam logic [3:0] FT_LOAD   = 4'b0100;
  localparam logic [3:0] FT_STORE  = 4'b0101;
  localparam logic [3:0] FT_JUMP   = 4'b1000;
  localparam logic [3:0] FT_BRANCH = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;

  localparam logic [7:0] OP_CMP = 8'h0B;

  // Where DECODE goes for a given class; wait and undefined classes
  // return to FETCH (the caller advances the PC in that case).
  function automatic state_t route_class(input logic [3:0] flag_type);
    case (flag_type)
      FT_R, FT_I:         return ST_EXEC;
      FT_LOAD:            return ST_MEM_RD;
      FT_STORE:           return ST_MEM_WR;
      FT_JUMP, FT_BRANCH: return ST_BRANCH;
      FT_WAIT:            return ST_FETCH;
      default:            return ST_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Bundle between the control FSM and the rest of the CPU.
// Decoder/PSR side (into the FSM):
//   stall, flag_type[3:0], opcode[7:0], cond[3:0], flag_z, flag_n
// Strobes and status (out of the FSM):
//   ir_we, pc_en, pc_ld, pc_src, mem_sel, mem_we, rf_we, wb_sel, psr_we,
//   state[2:0] (debug), retired[15:0] (completed-instruction count)
// master = control FSM, slave = datapath/decoder side.
interface control_fsm_if;

  logic        stall;
  logic [3:0]  flag_type;
  logic [7:0]  opcode;
  logic [3:0]  cond;
  logic        flag_z;
  logic        flag_n;

  logic        ir_we;
  logic        pc_en;
  logic        pc_ld;
  logic        pc_src;
  logic        mem_sel;
  logic        mem_we;
  logic        rf_we;
  logic        wb_sel;
  logic        psr_we;
  logic [2:0]  state;
  logic [15:0] retired;

  modport master (
    input  stall, flag_type, opcode, cond, flag_z, flag_n,
    output ir_we, pc_en, pc_ld, pc_src, mem_sel, mem_we, rf_we, wb_sel,
           psr_we, state, retired
  );

  modport slave (
    output stall, flag_type, opcode, cond, flag_z, flag_n,
    input  ir_we, pc_en, pc_ld, pc_src, mem_sel, mem_we, rf_we, wb_sel,
           psr_we, state, retired
  );

endinterface

// File: rtl/cond_eval.sv
// Branch/jump condition evaluator, shared between the control FSM and the
// datapath.
// Ports:
//   cond[3:0]  in   condition code (EQ, NE, GT, LE)
//   flag_z     in   PSR zero flag
//   flag_n     in   PSR negative flag
//   taken      out  condition holds; undefined codes are never taken
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       flag_z,
  input  logic       flag_n,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = flag_z;
      COND_NE: taken = !flag_z;
      COND_GT: taken = !flag_z && !flag_n;
      COND_LE: taken = flag_z || flag_n;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle CPU control sequencer.
// Ports:
//   clk    in  system clock, all state changes on the rising edge
//   reset  in  synchronous active-high reset (wins over stall)
//   bus    control_fsm_if.master - decoder/PSR inputs, strobes, debug state,
//          retired-instruction counter
//
// state     | meaning
// ----------+-----------------------------------------------------------
// FETCH  0  | load IR from memory at PC
// DECODE 1  | route on instruction class; wait/illegal advance PC here
// EXEC   2  | ALU op: flags, register write (not for cmp), PC+1
// MEM_RD 3  | load address on rsrc, memory read in flight
// LD_WB  4  | write memory data to register, PC+1
// MEM_WR 5  | store strobe, PC+1
// BRANCH 6  | jump/branch: load target if taken, otherwise PC+1
//
// Strobes are decoded combinationally from the state register so that a
// stall or reset in the current cycle suppresses them immediately; a
// registered copy would leak one cycle of strobes after either asserts.
module control_fsm
  import cpu_pkg::*;
(
  input logic          clk,
  input logic          reset,
  control_fsm_if.master bus
);

  state_t      state_q;
  state_t      decode_next;
  logic [15:0] retired_cnt;
  logic        taken;

  logic ir_we_c;
  logic pc_en_c;
  logic pc_ld_c;
  logic pc_src_c;
  logic mem_sel_c;
  logic mem_we_c;
  logic rf_we_c;
  logic wb_sel_c;
  logic psr_we_c;

  cond_eval u_cond_eval (
    .cond   (bus.cond),
    .flag_z (bus.flag_z),
    .flag_n (bus.flag_n),
    .taken  (taken)
  );

  assign decode_next = route_class(bus.flag_type);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FETCH;
      retired_cnt <= '0;
    end else if (!bus.stall) begin
      case (state_q)
        ST_FETCH:  state_q <= ST_DECODE;
        ST_DECODE: state_q <= decode_next;
        ST_MEM_RD: state_q <= ST_LD_WB;
        default:   state_q <= ST_FETCH;
      endcase
      // Each instruction retires exactly once, in the cycle it moves the PC.
      if (pc_en_c || pc_ld_c) begin
        retired_cnt <= retired_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    ir_we_c   = 1'b0;
    pc_en_c   = 1'b0;
    pc_ld_c   = 1'b0;
    pc_src_c  = 1'b0;
    mem_sel_c = 1'b0;
    mem_we_c  = 1'b0;
    rf_we_c   = 1'b0;
    wb_sel_c  = 1'b0;
    psr_we_c  = 1'b0;
    if (!reset && !bus.stall) begin
      case (state_q)
        ST_FETCH: begin
          ir_we_c = 1'b1;
        end
        ST_DECODE: begin
          // Wait and undefined classes complete here by stepping the PC.
          pc_en_c = (decode_next == ST_FETCH);
        end
        ST_EXEC: begin
          psr_we_c = 1'b1;
          pc_en_c  = 1'b1;
          rf_we_c  = (bus.opcode != OP_CMP);
        end
        ST_MEM_RD: begin
          mem_sel_c = 1'b1;
        end
        ST_LD_WB: begin
          rf_we_c  = 1'b1;
          wb_sel_c = 1'b1;
          pc_en_c  = 1'b1;
        end
        ST_MEM_WR: begin
          mem_sel_c = 1'b1;
          mem_we_c  = 1'b1;
          pc_en_c   = 1'b1;
        end
        ST_BRANCH: begin
          // pc_en and pc_ld are mutually exclusive by construction.
          if (taken) begin
            pc_ld_c  = 1'b1;
            // Class bit 2 separates branch (PC-relative) from jump (absolute).
            pc_src_c = bus.flag_type[2];
          end else begin
            pc_en_c = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ir_we   = ir_we_c;
  assign bus.pc_en   = pc_en_c;
  assign bus.pc_ld   = pc_ld_c;
  assign bus.pc_src  = pc_src_c;
  assign bus.mem_sel = mem_sel_c;
  assign bus.mem_we  = mem_we_c;
  assign bus.rf_we   = rf_we_c;
  assign bus.wb_sel  = wb_sel_c;
  assign bus.psr_we  = psr_we_c;
  assign bus.state   = state_q;
  assign bus.retired = retired_cnt;

endmodule

// File: tb/tb_control_fsm.sv
module tb_control_fsm;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  logic [15:0] exp_ret;

  always #5 clk = ~clk;

  control_fsm_if bus();

  control_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Strobe vector: ir_we pc_en pc_ld pc_src mem_sel mem_we rf_we wb_sel psr_we
  logic [8:0] strb;
  assign strb = {bus.ir_we, bus.pc_en, bus.pc_ld, bus.pc_src, bus.mem_sel,
                 bus.mem_we, bus.rf_we, bus.wb_sel, bus.psr_we};

  localparam logic [8:0] X_NONE  = 9'b000000000;
  localparam logic [8:0] X_FETCH = 9'b100000000;
  localparam logic [8:0] X_EXEC  = 9'b010000101;
  localparam logic [8:0] X_CMP   = 9'b010000001;
  localparam logic [8:0] X_MEMRD = 9'b000010000;
  localparam logic [8:0] X_LDWB  = 9'b010000110;
  localparam logic [8:0] X_MEMWR = 9'b010011000;
  localparam logic [8:0] X_BRTK  = 9'b001100000;
  localparam logic [8:0] X_JTK   = 9'b001000000;
  localparam logic [8:0] X_PCEN  = 9'b010000000;

  task automatic set_in(input logic [3:0] ft, input logic [7:0] op,
                        input logic [3:0] cd, input logic z, input logic n);
    bus.flag_type = ft;
    bus.opcode    = op;
    bus.cond      = cd;
    bus.flag_z    = z;
    bus.flag_n    = n;
    #1;
  endtask

  task automatic next_cyc;
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    bus.stall = 1'b0;
    set_in(4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0);
    next_cyc();
    next_cyc();
    total++;
    if (strb !== X_NONE) begin
      bad++;
      $display("FAIL reset_strobes: got %b want %b", strb, X_NONE);
    end
    total++;
    if (bus.state !== 3'd0) begin
      bad++;
      $display("FAIL reset_state: got %0d want 0", bus.state);
    end
    total++;
    if (bus.retired !== 16'd0) begin
      bad++;
      $display("FAIL reset_retired: got %0d want 0", bus.retired);
    end
    reset = 1'b0;
    #1;
    total++;
    if (strb !== X_FETCH) begin
      bad++;
      $display("FAIL post_reset_fetch: got %b want %b", strb, X_FETCH);
    end
    exp_ret = 16'd0;
  endtask

  // R/I ALU and cmp: FETCH, DECODE, EXEC, back to FETCH.
  task automatic test_alu;
    logic [3:0] fts [4];
    logic [7:0] ops [4];
    logic [8:0] exs [4];
    logic [2:0] es  [3];
    logic [8:0] ex  [3];
    fts = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    ops = '{8'h05,   8'h07,   8'h0B,   8'h0B};
    exs = '{X_EXEC,  X_EXEC,  X_CMP,   X_CMP};
    es  = '{3'd0, 3'd1, 3'd2};
    for (int k = 0; k < 4; k++) begin
      set_in(fts[k], ops[k], 4'b0000, 1'b0, 1'b0);
      ex = '{X_FETCH, X_NONE, exs[k]};
      for (int i = 0; i < 3; i++) begin
        total++;
        if (bus.state !== es[i] || strb !== ex[i]) begin
          bad++;
          $display("FAIL alu%0d cyc%0d: state=%0d strb=%b want state=%0d strb=%b",
                   k, i, bus.state, strb, es[i], ex[i]);
        end
        next_cyc();
      end
      exp_ret = exp_ret + 16'd1;
      total++;
      if (bus.state !== 3'd0 || bus.retired !== exp_ret) begin
        bad++;
        $display("FAIL alu%0d end: state=%0d retired=%0d want state=0 retired=%0d",
                 k, bus.state, bus.retired, exp_ret);
      end
    end
  endtask

  task automatic test_load;
    logic [2:0] es [4];
    logic [8:0] ex [4];
    es = '{3'd0, 3'd1, 3'd3, 3'd4};
    ex = '{X_FETCH, X_NONE, X_MEMRD, X_LDWB};
    set_in(4'b0100, 8'h20, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (bus.state !== es[i] || strb !== ex[i]) begin
        bad++;
        $display("FAIL load cyc%0d: state=%0d strb=%b want state=%0d strb=%b",
                 i, bus.state, strb, es[i], ex[i]);
      end
      next_cyc();
    end
    exp_ret = exp_ret + 16'd1;
    total++;
    if (bus.state !== 3'd0 || bus.retired !== exp_ret) begin
      bad++;
      $display("FAIL load end: state=%0d retired=%0d want state=0 retired=%0d",
               bus.state, bus.retired, exp_ret);
    end
  endtask

  task automatic test_store;
    logic [2:0] es [3];
    logic [8:0] ex [3];
    int nwe;
    nwe = 0;
    es = '{3'd0, 3'd1, 3'd5};
    ex = '{X_FETCH, X_NONE, X_MEMWR};
    set_in(4'b0101, 8'h21, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.state !== es[i] || strb !== ex[i]) begin
        bad++;
        $display("FAIL store cyc%0d: state=%0d strb=%b want state=%0d strb=%b",
                 i, bus.state, strb, es[i], ex[i]);
      end
      if (bus.mem_we === 1'b1) nwe++;
      next_cyc();
    end
    if (bus.mem_we === 1'b1) nwe++;
    exp_ret = exp_ret + 16'd1;
    total++;
    if (nwe != 1 || bus.state !== 3'd0 || bus.retired !== exp_ret) begin
      bad++;
      $display("FAIL store end: mem_we_cycles=%0d state=%0d retired=%0d want 1/0/%0d",
               nwe, bus.state, bus.retired, exp_ret);
    end
  endtask

  task automatic test_branch;
    logic [3:0] fts [6];
    logic [3:0] cds [6];
    logic       zs  [6];
    logic       ns  [6];
    logic [8:0] exs [6];
    logic [2:0] es  [3];
    logic [8:0] ex  [3];
    // BNE z=0, BNE z=1, JGT n=1, JEQ z=1, BLE n=1, undefined cond
    fts = '{4'b1100, 4'b1100, 4'b1000, 4'b1000, 4'b1100, 4'b1100};
    cds = '{4'b0001, 4'b0001, 4'b0110, 4'b0000, 4'b0111, 4'b0011};
    zs  = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b1};
    ns  = '{1'b0,    1'b0,    1'b1,    1'b0,    1'b1,    1'b1};
    exs = '{X_BRTK,  X_PCEN,  X_PCEN,  X_JTK,   X_BRTK,  X_PCEN};
    es  = '{3'd0, 3'd1, 3'd6};
    for (int k = 0; k < 6; k++) begin
      set_in(fts[k], 8'h30, cds[k], zs[k], ns[k]);
      ex = '{X_FETCH, X_NONE, exs[k]};
      for (int i = 0; i < 3; i++) begin
        total++;
        if (bus.state !== es[i] || strb !== ex[i]) begin
          bad++;
          $display("FAIL branch%0d cyc%0d: state=%0d strb=%b want state=%0d strb=%b",
                   k, i, bus.state, strb, es[i], ex[i]);
        end
        next_cyc();
      end
      exp_ret = exp_ret + 16'd1;
      total++;
      if (bus.state !== 3'd0 || bus.retired !== exp_ret) begin
        bad++;
        $display("FAIL branch%0d end: state=%0d retired=%0d want state=0 retired=%0d",
                 k, bus.state, bus.retired, exp_ret);
      end
    end
  endtask

  // Wait and illegal classes: two-cycle FETCH, DECODE(pc_en).
  task automatic test_wait;
    logic [3:0] fts [3];
    logic [2:0] es  [2];
    logic [8:0] ex  [2];
    fts = '{4'b0000, 4'b0011, 4'b1111};
    es  = '{3'd0, 3'd1};
    ex  = '{X_FETCH, X_PCEN};
    for (int k = 0; k < 3; k++) begin
      set_in(fts[k], 8'h00, 4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (bus.state !== es[i] || strb !== ex[i]) begin
          bad++;
          $display("FAIL wait%0d cyc%0d: state=%0d strb=%b want state=%0d strb=%b",
                   k, i, bus.state, strb, es[i], ex[i]);
        end
        next_cyc();
      end
      exp_ret = exp_ret + 16'd1;
      total++;
      if (bus.state !== 3'd0 || bus.retired !== exp_ret) begin
        bad++;
        $display("FAIL wait%0d end: state=%0d retired=%0d want state=0 retired=%0d",
                 k, bus.state, bus.retired, exp_ret);
      end
    end
  endtask

  task automatic test_stall;
    set_in(4'b0001, 8'h05, 4'b0000, 1'b0, 1'b0);
    next_cyc();
    next_cyc();
    for (int i = 0; i < 3; i++) begin
      bus.stall = 1'b1;
      #1;
      total++;
      if (bus.state !== 3'd2 || strb !== X_NONE || bus.retired !== exp_ret) begin
        bad++;
        $display("FAIL stall cyc%0d: state=%0d strb=%b retired=%0d want 2/%b/%0d",
                 i, bus.state, strb, bus.retired, X_NONE, exp_ret);
      end
      next_cyc();
    end
    bus.stall = 1'b0;
    #1;
    total++;
    if (bus.state !== 3'd2 || strb !== X_EXEC) begin
      bad++;
      $display("FAIL stall_release: state=%0d strb=%b want 2/%b", bus.state, strb, X_EXEC);
    end
    next_cyc();
    exp_ret = exp_ret + 16'd1;
    total++;
    if (bus.state !== 3'd0 || strb !== X_FETCH || bus.retired !== exp_ret) begin
      bad++;
      $display("FAIL stall_end: state=%0d strb=%b retired=%0d want 0/%b/%0d",
               bus.state, strb, bus.retired, X_FETCH, exp_ret);
    end
  endtask

  // Reset (together with stall) arriving in MEM_WR.
  task automatic test_reset_mid;
    set_in(4'b0101, 8'h21, 4'b0000, 1'b0, 1'b0);
    next_cyc();
    next_cyc();
    total++;
    if (bus.state !== 3'd5 || strb !== X_MEMWR) begin
      bad++;
      $display("FAIL rst_mid_pre: state=%0d strb=%b want 5/%b", bus.state, strb, X_MEMWR);
    end
    reset     = 1'b1;
    bus.stall = 1'b1;
    #1;
    total++;
    if (strb !== X_NONE) begin
      bad++;
      $display("FAIL rst_mid_strobes: got %b want %b", strb, X_NONE);
    end
    next_cyc();
    total++;
    if (bus.state !== 3'd0 || bus.retired !== 16'd0 || strb !== X_NONE) begin
      bad++;
      $display("FAIL rst_mid_after: state=%0d retired=%0d strb=%b want 0/0/%b",
               bus.state, bus.retired, strb, X_NONE);
    end
    reset     = 1'b0;
    bus.stall = 1'b0;
    #1;
    total++;
    if (strb !== X_FETCH) begin
      bad++;
      $display("FAIL rst_mid_fetch: got %b want %b", strb, X_FETCH);
    end
    exp_ret = 16'd0;
  endtask

  task automatic test_wrap;
    force dut.retired_cnt = 16'hFFFF;
    #1;
    release dut.retired_cnt;
    set_in(4'b0000, 8'h00, 4'b0000, 1'b0, 1'b0);
    next_cyc();
    next_cyc();
    total++;
    if (bus.state !== 3'd0 || bus.retired !== 16'h0000) begin
      bad++;
      $display("FAIL wrap: state=%0d retired=%h want 0/0000", bus.state, bus.retired);
    end
    set_in(4'b0001, 8'h05, 4'b0000, 1'b0, 1'b0);
    next_cyc();
    next_cyc();
    next_cyc();
    total++;
    if (bus.state !== 3'd0 || bus.retired !== 16'h0001) begin
      bad++;
      $display("FAIL wrap_next: state=%0d retired=%h want 0/0001", bus.state, bus.retired);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_branch();
    test_wait();
    test_stall();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
